// File: rtl/can_pkg.sv
// Shared CAN receive-path types and constants.
package can_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DYNAMIC,
    FIXED
  } stuff_state_t;

  localparam int unsigned CAN_DYN_LIMIT      = 5;
  localparam int unsigned CANFD_FIXED_PERIOD = 4;

endpackage

// File: rtl/stuffcount_gray.sv
// 3-bit binary to gray conversion with even parity over the gray bits.
module stuffcount_gray (
  input  logic [2:0] bin,
  output logic [2:0] gray,
  output logic       parity
);

  always_comb begin
    gray   = bin ^ (bin >> 1);
    parity = ^gray;
  end

endmodule

// File: rtl/bitstuff_ctrl.sv
// Receive-side bit-stuffing controller: flags stuff bits, checks them, and keeps
// the mod-8 dynamic stuff count for the CAN FD stuff-count field.
module bitstuff_ctrl
  import can_pkg::*;
#(
  parameter int unsigned DYN_LIMIT    = CAN_DYN_LIMIT,
  parameter int unsigned FIXED_PERIOD = CANFD_FIXED_PERIOD
) (
  input  logic       sp,
  input  logic       reset,
  input  logic       CAN_RX,
  input  logic       BSonoff,
  input  logic       CRCtime,
  input  logic       EDL,
  input  logic       errorFlag,
  input  logic       frameReady,
  output logic       isStuff,
  output logic       stuffError,
  output logic [2:0] stuffCountGray,
  output logic       stuffParity
);

  localparam logic [2:0] DynLimitW    = 3'(DYN_LIMIT);
  localparam logic [2:0] FixedPeriodW = 3'(FIXED_PERIOD);

  stuff_state_t state;

  logic       last_bit_q, last_bit_d;
  logic [2:0] run_len_q, run_len_d;
  logic [2:0] fix_cnt_q, fix_cnt_d;
  logic [2:0] dyn_cnt_q, dyn_cnt_d;
  logic       fixed_seen_q, fixed_seen_d;
  logic       is_stuff_q, is_stuff_d;
  logic       stuff_error_q, stuff_error_d;

  logic       same_bit;
  logic [2:0] run_next;
  logic [2:0] fix_next;

  always_ff @(posedge sp or posedge reset) begin
    if (reset) begin
      last_bit_q    <= 1'b1;
      run_len_q     <= 3'd1;
      fix_cnt_q     <= 3'd0;
      dyn_cnt_q     <= 3'd0;
      fixed_seen_q  <= 1'b0;
      is_stuff_q    <= 1'b0;
      stuff_error_q <= 1'b0;
    end else begin
      last_bit_q    <= last_bit_d;
      run_len_q     <= run_len_d;
      fix_cnt_q     <= fix_cnt_d;
      dyn_cnt_q     <= dyn_cnt_d;
      fixed_seen_q  <= fixed_seen_d;
      is_stuff_q    <= is_stuff_d;
      stuff_error_q <= stuff_error_d;
    end
  end

  always_comb begin
    state = IDLE;
    if (EDL && CRCtime) begin
      state = FIXED;
    end else if (BSonoff) begin
      state = DYNAMIC;
    end
  end

  always_comb begin
    last_bit_d    = CAN_RX;
    run_len_d     = run_len_q;
    fix_cnt_d     = fix_cnt_q;
    dyn_cnt_d     = dyn_cnt_q;
    fixed_seen_d  = fixed_seen_q;
    is_stuff_d    = 1'b0;
    stuff_error_d = 1'b0;
    same_bit      = (CAN_RX == last_bit_q);
    run_next      = same_bit ? run_len_q + 3'd1 : 3'd1;
    fix_next      = fix_cnt_q + 3'd1;

    if (errorFlag) begin
      run_len_d    = 3'd1;
      fix_cnt_d    = 3'd0;
      fixed_seen_d = 1'b0;
      dyn_cnt_d    = 3'd0;
    end else if (frameReady) begin
      run_len_d    = 3'd1;
      fixed_seen_d = 1'b0;
      dyn_cnt_d    = 3'd0;
    end else begin
      unique case (state)
        IDLE: begin
          run_len_d    = 3'd1;
          fixed_seen_d = 1'b0;
        end
        DYNAMIC: begin
          if (is_stuff_q) begin
            // The stuff bit itself opens the next run.
            stuff_error_d = same_bit;
            dyn_cnt_d     = dyn_cnt_q + 3'd1;
            run_len_d     = 3'd1;
          end else begin
            run_len_d  = run_next;
            is_stuff_d = (run_next == DynLimitW);
          end
        end
        FIXED: begin
          if (!fixed_seen_q) begin
            // Entry edge: the first CRC bit is always a fixed stuff bit.
            fixed_seen_d = 1'b1;
            is_stuff_d   = 1'b1;
            fix_cnt_d    = 3'd0;
          end else if (is_stuff_q) begin
            stuff_error_d = same_bit;
            fix_cnt_d     = 3'd0;
          end else begin
            fix_cnt_d  = fix_next;
            is_stuff_d = (fix_next == FixedPeriodW);
          end
        end
        default: begin
          run_len_d = 3'd1;
        end
      endcase
    end
  end

  assign isStuff    = is_stuff_q;
  assign stuffError = stuff_error_q;

  stuffcount_gray u_stuffcount_gray (
    .bin    (dyn_cnt_q),
    .gray   (stuffCountGray),
    .parity (stuffParity)
  );

endmodule

// File: tb/tb_bitstuff_ctrl.sv
// Directed, table-driven bench for bitstuff_ctrl.
module tb_bitstuff_ctrl;

  logic       sp;
  logic       reset;
  logic       CAN_RX;
  logic       BSonoff;
  logic       CRCtime;
  logic       EDL;
  logic       errorFlag;
  logic       frameReady;
  logic       isStuff;
  logic       stuffError;
  logic [2:0] stuffCountGray;
  logic       stuffParity;

  int total;
  int bad;

  typedef struct {
    logic       bs;
    logic       crc;
    logic       edl;
    logic       ef;
    logic       fr;
    logic       rx;
    logic       exp_stuff;
    logic       exp_err;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  logic [2:0] gray_lut [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
  logic       par_lut  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  bitstuff_ctrl dut (
    .sp             (sp),
    .reset          (reset),
    .CAN_RX         (CAN_RX),
    .BSonoff        (BSonoff),
    .CRCtime        (CRCtime),
    .EDL            (EDL),
    .errorFlag      (errorFlag),
    .frameReady     (frameReady),
    .isStuff        (isStuff),
    .stuffError     (stuffError),
    .stuffCountGray (stuffCountGray),
    .stuffParity    (stuffParity)
  );

  initial sp = 1'b0;
  always #5 sp = ~sp;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int idx, input logic [2:0] act,
                     input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0b want %0b", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic bs, input logic crc, input logic edl, input logic ef,
                     input logic fr, input logic rx, input logic es, input logic ee,
                     input int cnt);
    vec_t v;
    v.bs = bs; v.crc = crc; v.edl = edl; v.ef = ef; v.fr = fr; v.rx = rx;
    v.exp_stuff = es; v.exp_err = ee; v.exp_cnt = 3'(cnt);
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int idx);
    BSonoff = v.bs; CRCtime = v.crc; EDL = v.edl;
    errorFlag = v.ef; frameReady = v.fr; CAN_RX = v.rx;
    @(posedge sp);
    #1;
    chk("isStuff", idx, {2'b0, isStuff}, {2'b0, v.exp_stuff});
    chk("stuffError", idx, {2'b0, stuffError}, {2'b0, v.exp_err});
    chk("stuffCountGray", idx, stuffCountGray, gray_lut[v.exp_cnt]);
    chk("stuffParity", idx, {2'b0, stuffParity}, {2'b0, par_lut[v.exp_cnt]});
  endtask

  task automatic dyn(input logic rx, input logic es, input logic ee, input int cnt);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rx, es, ee, cnt);
  endtask

  task automatic fix(input logic rx, input logic es, input logic ee, input int cnt);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rx, es, ee, cnt);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_isStuff"}, 0, {2'b0, isStuff}, 3'b000);
    chk({name, "_stuffError"}, 0, {2'b0, stuffError}, 3'b000);
    chk({name, "_gray"}, 0, stuffCountGray, 3'b000);
    chk({name, "_parity"}, 0, {2'b0, stuffParity}, 3'b000);
  endtask

  initial begin
    int  cnt;
    logic val;
    vec_t v;

    total = 0;
    bad = 0;
    reset = 1'b1;
    CAN_RX = 1'b1; BSonoff = 1'b0; CRCtime = 1'b0; EDL = 1'b0;
    errorFlag = 1'b0; frameReady = 1'b0;
    #2;
    check_zero("reset");
    #4 reset = 1'b0;

    // Idle, then 0,0,0,0,0 + stuff 1 + 0.
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 4; i++) dyn(1'b0, 1'b0, 1'b0, 0);
    dyn(1'b0, 1'b1, 1'b0, 0);
    dyn(1'b1, 1'b0, 1'b0, 1);
    dyn(1'b0, 1'b0, 1'b0, 1);
    // Six ones: the sixth is a bad stuff bit.
    for (int i = 0; i < 4; i++) dyn(1'b1, 1'b0, 1'b0, 1);
    dyn(1'b1, 1'b1, 1'b0, 1);
    dyn(1'b1, 1'b0, 1'b1, 2);
    dyn(1'b0, 1'b0, 1'b0, 2);
    // Stuff bit 1 then 1,1,1,1 forms a new run of five.
    for (int i = 0; i < 3; i++) dyn(1'b0, 1'b0, 1'b0, 2);
    dyn(1'b0, 1'b1, 1'b0, 2);
    dyn(1'b1, 1'b0, 1'b0, 3);
    for (int i = 0; i < 3; i++) dyn(1'b1, 1'b0, 1'b0, 3);
    dyn(1'b1, 1'b1, 1'b0, 3);
    dyn(1'b0, 1'b0, 1'b0, 4);
    // Five more stuff bits: count wraps to 9 mod 8 = 1.
    cnt = 4;
    val = 1'b0;
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 3; i++) dyn(val, 1'b0, 1'b0, cnt);
      dyn(val, 1'b1, 1'b0, cnt);
      cnt++;
      dyn(~val, 1'b0, 1'b0, cnt % 8);
      val = ~val;
    end
    // FD CRC field with fixed stuffing; count frozen at 1.
    fix(1'b1, 1'b1, 1'b0, 1);
    fix(1'b0, 1'b0, 1'b0, 1);
    fix(1'b1, 1'b0, 1'b0, 1);
    fix(1'b0, 1'b0, 1'b0, 1);
    fix(1'b1, 1'b0, 1'b0, 1);
    fix(1'b1, 1'b1, 1'b0, 1);
    fix(1'b1, 1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) fix(1'b0, 1'b0, 1'b0, 1);
    fix(1'b0, 1'b1, 1'b0, 1);
    fix(1'b1, 1'b0, 1'b0, 1);
    // End of frame clears the count.
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    // errorFlag on a pending stuff bit that would otherwise fail.
    for (int i = 0; i < 4; i++) dyn(1'b0, 1'b0, 1'b0, 0);
    dyn(1'b0, 1'b1, 1'b0, 0);
    dyn(1'b1, 1'b0, 1'b0, 1);
    for (int i = 0; i < 3; i++) dyn(1'b1, 1'b0, 1'b0, 1);
    dyn(1'b1, 1'b1, 1'b0, 1);
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    dyn(1'b1, 1'b0, 1'b0, 0);
    // BSonoff drops with a stuff bit pending: no check made.
    for (int i = 0; i < 2; i++) dyn(1'b1, 1'b0, 1'b0, 0);
    dyn(1'b1, 1'b1, 1'b0, 0);
    add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Async reset during a run of four equal bits with a nonzero count.
    vecs.delete();
    for (int i = 0; i < 4; i++) dyn(1'b0, 1'b0, 1'b0, 0);
    dyn(1'b0, 1'b1, 1'b0, 0);
    dyn(1'b1, 1'b0, 1'b0, 1);
    for (int i = 0; i < 3; i++) dyn(1'b1, 1'b0, 1'b0, 1);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 1000 + i);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    #1 reset = 1'b0;
    vecs.delete();
    for (int i = 0; i < 4; i++) dyn(1'b0, 1'b0, 1'b0, 0);
    dyn(1'b0, 1'b1, 1'b0, 0);
    dyn(1'b1, 1'b0, 1'b0, 1);
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 2000 + i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
